// File: rtl/rptr_empty_if.sv
// Read-side bundle between the FIFO read-pointer block and its consumer.
// The slave modport is the rptr_empty block; the master modport is the consumer.
// The almost_empty signal exists only when RPTR_ALMOST_EMPTY_EN is defined.
interface rptr_empty_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  rd_en;
    logic [ADDR_WIDTH:0]   rq2_wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  empty;
    logic                  rd_fire;
    logic                  underflow;
    logic [ADDR_WIDTH:0]   rd_count;
`ifdef RPTR_ALMOST_EMPTY_EN
    logic                  almost_empty;
`endif

    modport slave (
        input  rd_en,
        input  rq2_wptr,
        output rptr,
        output raddr,
        output empty,
        output rd_fire,
        output underflow,
`ifdef RPTR_ALMOST_EMPTY_EN
        output almost_empty,
`endif
        output rd_count
    );

    modport master (
        output rd_en,
        output rq2_wptr,
        input  rptr,
        input  raddr,
        input  empty,
        input  rd_fire,
        input  underflow,
`ifdef RPTR_ALMOST_EMPTY_EN
        input  almost_empty,
`endif
        input  rd_count
    );
endinterface

// File: rtl/rptr_empty.sv
// Async-FIFO read-pointer / empty-flag block (read clock domain).
// Keeps a binary read pointer plus its registered Gray copy for the write
// domain, and derives empty, occupancy and underflow from the synchronized
// Gray write pointer. Optional almost_empty flag: define RPTR_ALMOST_EMPTY_EN.
module rptr_empty #(
    parameter int ADDR_WIDTH = 4,
    parameter int AE_THRESH  = 2
) (
    input logic        clk,
    input logic        reset,
    rptr_empty_if.slave rif
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // A threshold outside 0..DEPTH would make almost_empty constant.
    if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_thresh
        $error("rptr_empty: AE_THRESH out of range 0..2^ADDR_WIDTH");
    end

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rgray_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          empty_q, empty_d;
    logic          unf_q, unf_d;
    logic          fire;

    // Read accepted only against the registered empty flag.
    assign fire = rif.rd_en & ~empty_q;

    // Next pointer, its Gray form, and the flags evaluated against the
    // current synchronized write pointer (so a same-cycle write advance
    // keeps empty low when the last word is read).
    always_comb begin
        rbin_d  = rbin_q + {{ADDR_WIDTH{1'b0}}, fire};
        rgray_d = rbin_d ^ (rbin_d >> 1);
        empty_d = (rgray_d == rif.rq2_wptr);
        cnt_d   = gray2bin(rif.rq2_wptr) - rbin_d;
        unf_d   = rif.rd_en & empty_q;
    end

    // Pointer and status registers; everything clears asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rbin_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            unf_q   <= 1'b0;
        end else begin
            rbin_q  <= rbin_d;
            rptr_q  <= rgray_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            unf_q   <= unf_d;
        end
    end

    assign rif.rptr      = rptr_q;
    assign rif.raddr     = rbin_q[ADDR_WIDTH-1:0];
    assign rif.empty     = empty_q;
    assign rif.rd_fire   = fire;
    assign rif.underflow = unf_q;
    assign rif.rd_count  = cnt_q;

`ifdef RPTR_ALMOST_EMPTY_EN
    logic ae_q;

    // Almost-empty tracks the same next occupancy as rd_count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ae_q <= 1'b1;
        else       ae_q <= (cnt_d <= PW'(AE_THRESH));
    end

    assign rif.almost_empty = ae_q;
`endif
endmodule

// File: tb/tb_rptr_empty.sv
// Directed self-checking bench for rptr_empty (ADDR_WIDTH=4, AE_THRESH=2).
module tb_rptr_empty;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    rptr_empty_if #(.ADDR_WIDTH(4)) rif ();

    rptr_empty #(.ADDR_WIDTH(4), .AE_THRESH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .rif   (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] g(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rif.rd_en = 1'b0;
        rif.rq2_wptr = '0;
        tick();
        tick();
        checks++; if (rif.rptr !== 5'd0) begin errors++; $display("FAIL reset_rptr got %b want 00000", rif.rptr); end
        checks++; if (rif.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", rif.empty); end
        checks++; if (rif.rd_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", rif.rd_count); end
        checks++; if (rif.underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b want 0", rif.underflow); end
`ifdef RPTR_ALMOST_EMPTY_EN
        checks++; if (rif.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got %b want 1", rif.almost_empty); end
`endif
        reset = 1'b0;
        tick();
        checks++; if (rif.empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty got %b want 1", rif.empty); end
    endtask

    task automatic test_fill_drain();
        logic [4:0] exp_ptr [3];
        exp_ptr[0] = 5'b00001; exp_ptr[1] = 5'b00011; exp_ptr[2] = 5'b00010;
        rif.rq2_wptr = 5'b00010;
        #1;
        checks++; if (rif.empty !== 1'b1) begin errors++; $display("FAIL latency_empty got %b want 1", rif.empty); end
        tick();
        checks++; if (rif.empty !== 1'b0) begin errors++; $display("FAIL fill_empty got %b want 0", rif.empty); end
        checks++; if (rif.rd_count !== 5'd3) begin errors++; $display("FAIL fill_count got %0d want 3", rif.rd_count); end
        rif.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rif.raddr !== 4'(i)) begin errors++; $display("FAIL drain_raddr%0d got %0d want %0d", i, rif.raddr, i); end
            checks++; if (rif.rd_fire !== 1'b1) begin errors++; $display("FAIL drain_fire%0d got %b want 1", i, rif.rd_fire); end
            tick();
            checks++; if (rif.rptr !== exp_ptr[i]) begin errors++; $display("FAIL drain_rptr%0d got %b want %b", i, rif.rptr, exp_ptr[i]); end
        end
        rif.rd_en = 1'b0;
        checks++; if (rif.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", rif.empty); end
        checks++; if (rif.rd_count !== 5'd0) begin errors++; $display("FAIL drain_count got %0d want 0", rif.rd_count); end
    endtask

    task automatic test_underflow();
        rif.rd_en = 1'b1;
        #1;
        checks++; if (rif.rd_fire !== 1'b0) begin errors++; $display("FAIL unf_fire got %b want 0", rif.rd_fire); end
        tick();
        rif.rd_en = 1'b0;
        checks++; if (rif.underflow !== 1'b1) begin errors++; $display("FAIL unf_pulse got %b want 1", rif.underflow); end
        checks++; if (rif.rptr !== 5'b00010) begin errors++; $display("FAIL unf_rptr got %b want 00010", rif.rptr); end
        tick();
        checks++; if (rif.underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b want 0", rif.underflow); end
        checks++; if (rif.rptr !== 5'b00010) begin errors++; $display("FAIL unf_rptr2 got %b want 00010", rif.rptr); end
    endtask

    task automatic test_reset_mid();
        // rbin 3 -> 4 (Gray 00110) while writer sits at bin 6.
        rif.rq2_wptr = 5'b00101;
        tick();
        rif.rd_en = 1'b1;
        tick();
        rif.rd_en = 1'b0;
        checks++; if (rif.rptr !== 5'b00110) begin errors++; $display("FAIL mid_pre_rptr got %b want 00110", rif.rptr); end
        checks++; if (rif.rd_count !== 5'd2) begin errors++; $display("FAIL mid_pre_count got %0d want 2", rif.rd_count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (rif.rptr !== 5'd0) begin errors++; $display("FAIL mid_rptr got %b want 00000", rif.rptr); end
        checks++; if (rif.empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", rif.empty); end
        checks++; if (rif.rd_count !== 5'd0) begin errors++; $display("FAIL mid_count got %0d want 0", rif.rd_count); end
        checks++; if (rif.underflow !== 1'b0) begin errors++; $display("FAIL mid_underflow got %b want 0", rif.underflow); end
        rif.rq2_wptr = '0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        logic [4:0] prev;
        rif.rq2_wptr = g(8);
        tick();
        checks++; if (rif.rd_count !== 5'd8) begin errors++; $display("FAIL stream_start got %0d want 8", rif.rd_count); end
        rif.rd_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            prev = rif.rptr;
            checks++; if (rif.raddr !== 4'(i % 16)) begin errors++; $display("FAIL stream_raddr%0d got %0d want %0d", i, rif.raddr, i % 16); end
            rif.rq2_wptr = g((i + 9) % 32);
            tick();
            checks++; if (rif.rptr !== g((i + 1) % 32)) begin errors++; $display("FAIL stream_rptr%0d got %b want %b", i, rif.rptr, g((i + 1) % 32)); end
            checks++; if ($countones(prev ^ rif.rptr) != 1) begin errors++; $display("FAIL stream_onebit%0d got %b->%b want 1 bit change", i, prev, rif.rptr); end
            checks++; if (rif.empty !== 1'b0 || rif.rd_count !== 5'd8) begin errors++; $display("FAIL stream_state%0d got e=%b c=%0d want e=0 c=8", i, rif.empty, rif.rd_count); end
        end
        rif.rd_en = 1'b0;
        checks++; if (rif.rptr !== 5'd0) begin errors++; $display("FAIL stream_wrap got %b want 00000", rif.rptr); end
    endtask

    task automatic test_full();
        rif.rq2_wptr = 5'b11000;
        tick();
        checks++; if (rif.rd_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", rif.rd_count); end
        checks++; if (rif.empty !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", rif.empty); end
    endtask

    task automatic test_back_to_back();
        // One word left; read it while the writer adds another.
        rif.rq2_wptr = 5'b00001;
        tick();
        checks++; if (rif.rd_count !== 5'd1) begin errors++; $display("FAIL b2b_pre got %0d want 1", rif.rd_count); end
        rif.rd_en = 1'b1;
        rif.rq2_wptr = 5'b00011;
        tick();
        rif.rd_en = 1'b0;
        checks++; if (rif.empty !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", rif.empty); end
        checks++; if (rif.rd_count !== 5'd1) begin errors++; $display("FAIL b2b_count got %0d want 1", rif.rd_count); end
        checks++; if (rif.rptr !== 5'b00001) begin errors++; $display("FAIL b2b_rptr got %b want 00001", rif.rptr); end
    endtask

`ifdef RPTR_ALMOST_EMPTY_EN
    task automatic test_almost_empty();
        rif.rq2_wptr = 5'b00110; // bin 4, rbin 1 -> count 3
        tick();
        checks++; if (rif.almost_empty !== 1'b0) begin errors++; $display("FAIL ae_at3 got %b want 0", rif.almost_empty); end
        rif.rd_en = 1'b1;
        tick();
        rif.rd_en = 1'b0;
        checks++; if (rif.rd_count !== 5'd2 || rif.almost_empty !== 1'b1) begin errors++; $display("FAIL ae_rise got c=%0d ae=%b want c=2 ae=1", rif.rd_count, rif.almost_empty); end
        rif.rq2_wptr = 5'b00111; // bin 5 -> count 3
        tick();
        checks++; if (rif.rd_count !== 5'd3 || rif.almost_empty !== 1'b0) begin errors++; $display("FAIL ae_fall got c=%0d ae=%b want c=3 ae=0", rif.rd_count, rif.almost_empty); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_underflow();
        test_reset_mid();
        test_stream();
        test_full();
        test_back_to_back();
`ifdef RPTR_ALMOST_EMPTY_EN
        test_almost_empty();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: FIFO depth 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
REQ-002 SHALL have parameter AE_THRESH, default 2: almost-empty level, used only under ALMOST_EMPTY_EN.
REQ-003 SHALL have port clk  input  1  read-domain clock; the only clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rd_en  input  1  read request from the consumer.
REQ-006 SHALL have port rq2_wptr  input  ADDR_WIDTH+1  Gray write pointer, already synchronized into clk domain.
REQ-007 SHALL have port rptr  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write-domain synchronizer.
REQ-008 SHALL have port raddr  output  ADDR_WIDTH  binary RAM read address.
REQ-009 SHALL have port empty  output  1  registered empty flag.
REQ-010 SHALL have port rd_fire  output  1  combinational rd_en & ~empty; a read is accepted this cycle.
REQ-011 SHALL have port underflow  output  1  registered one-cycle pulse: read attempted while empty.
REQ-012 SHALL have port rd_count  output  ADDR_WIDTH+1  registered occupancy as seen by read side, 0..2^ADDR_WIDTH.
REQ-013 SHALL have port almost_empty  output  1  registered; present only under ALMOST_EMPTY_EN.

Function
REQ-014 SHALL hold internal binary pointer rbin (ADDR_WIDTH+1 bits); rbin_next = rbin + rd_fire, modulo 2^(ADDR_WIDTH+1).
REQ-015 SHALL compute rgray_next = rbin_next ^ (rbin_next >> 1); rptr <= rgray_next each clk.
REQ-016 SHALL drive raddr = rbin[ADDR_WIDTH-1:0], combinationally from the register; the addressed word is the one consumed by rd_fire.
REQ-017 SHALL register empty <= (rgray_next == rq2_wptr); a full Gray compare including the MSB.
REQ-018 SHALL register rd_count <= gray2bin(rq2_wptr) - rbin_next, modulo 2^(ADDR_WIDTH+1).
REQ-019 SHALL register underflow <= rd_en & empty; rbin and rptr SHALL NOT advance on an underflow attempt.
REQ-020 SHALL change at most one bit of rptr per clk; rptr SHALL never glitch because it is a flop output.
REQ-021 SHALL have 1-cycle latency from an rq2_wptr change to empty/rd_count update.
REQ-022 SHALL, on a simultaneous read of the last word and a rq2_wptr advance, evaluate empty against the new rq2_wptr (empty stays 0).
REQ-023 SHALL wrap naturally: raddr 2^ADDR_WIDTH-1 -> 0, with rptr MSB toggling; rptr returns to 0 after 2^(ADDR_WIDTH+1) reads.
REQ-024 SHALL report rd_count = 2^ADDR_WIDTH (full) when rq2_wptr and rptr differ only in their top two Gray bits.

Reset
REQ-025 SHALL, while reset=1 and independent of clk, hold rbin=0, rptr=0, empty=1, rd_count=0, underflow=0, almost_empty=1.
REQ-026 SHALL, on reset asserted mid-operation, clear all state immediately; there are no pending reads after release.
REQ-027 SHALL resume normal update on the first rising clk edge after reset falls.

Configuration
REQ-028 SHALL, when RPTR_ALMOST_EMPTY_EN is defined, include the almost_empty port, registered as almost_empty <= (next rd_count <= AE_THRESH).
REQ-029 SHALL, when RPTR_ALMOST_EMPTY_EN is undefined, omit the almost_empty port and its logic; all other behaviour stays identical.

Verification (ADDR_WIDTH=4)
REQ-030 SHALL test: assert reset between edges with rptr=5'b00110 -> rptr=0, empty=1, rd_count=0, underflow=0 before the next edge.
REQ-031 SHALL test: rq2_wptr=5'b00010 (bin 3), rd_en=0 -> next edge empty=0, rd_count=3; then rd_en=1 for 3 cycles -> raddr 0,1,2; rptr 00001,00011,00010; empty=1 and rd_count=0 after the 3rd edge.
REQ-032 SHALL test: empty=1, rd_en=1 -> rd_fire=0, rptr unchanged, underflow=1 for exactly one cycle.
REQ-033 SHALL test: continuous stream of 32 reads with writer ahead -> each rptr step changes one bit; raddr 15->0 at read 16; rptr=0 after read 32.
REQ-034 SHALL test: rptr=0, rq2_wptr=5'b11000 (bin 16) -> rd_count=16, empty=0.
REQ-035 SHALL test, with RPTR_ALMOST_EMPTY_EN and AE_THRESH=2: rd_count 3->2 -> almost_empty rises on the same edge; rd_count 2->3 -> almost_empty falls.
